// File: rtl/pwm_duty_stepper_pkg.sv
// Shared constants for the PWM duty stepper: default period, reset duty, debounce divider.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package pwm_duty_stepper_pkg;

  localparam int DEFAULT_DEBOUNCE_DIV = 4;
  localparam int DEFAULT_PERIOD_STEPS = 10;
  localparam int DEFAULT_DUTY_RESET   = 5;

  // Duty must be able to hold 0..steps inclusive.
  function automatic int duty_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/pwm_duty_stepper_if.sv
// User-facing signals of the duty stepper tile: enable, two raw buttons, PWM output.
// Latency: n/a (wires only).
// Backpressure: none; buttons are level inputs, PWM_OUT is a free-running waveform.
//   master: drives ena / ui_increase_duty / ui_decrease_duty, observes PWM_OUT
//   slave : the stepper itself
interface pwm_duty_stepper_if;
  logic ena;
  logic ui_increase_duty;
  logic ui_decrease_duty;
  logic PWM_OUT;

  modport master (output ena, output ui_increase_duty, output ui_decrease_duty, input PWM_OUT);
  modport slave  (input ena, input ui_increase_duty, input ui_decrease_duty, output PWM_OUT);
endinterface

// File: rtl/pwm_duty_stepper_button_debouncer.sv
// Button conditioner: 2-flop synchroniser, tick-sampled s1/s2 history, one-clock press pulse.
// Latency: press reported on the second consecutive high tick sample (2 clk sync + up to 2 ticks).
// Backpressure: none; evt is a single-cycle pulse the consumer must take.
//   ports: clk, rst_n (async, active-high), btn_raw (async bouncy), tick (shared sample strobe), evt
module button_debouncer (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic tick,
  output logic evt
);

  logic [1:0] sync_q, sync_d;
  logic       s1_q, s1_d;
  logic       s2_q, s2_d;

  always_comb begin
    sync_d = {sync_q[0], btn_raw};
    s1_d   = s1_q;
    s2_d   = s2_q;
    if (tick) begin
      s1_d = sync_q[1];
      s2_d = s1_q;
    end
    // High now and on the previous tick, low on the one before: a fresh press.
    // s2 stays high while the button is held, so a hold yields a single pulse.
    evt = tick & sync_q[1] & s1_q & ~s2_q;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_q <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

endmodule

// File: rtl/pwm_duty_stepper.sv
// Fixed-period PWM whose duty is stepped +/-1 step by two debounced push buttons.
// Latency: PWM_OUT registered one clk after the counter; new duty takes effect at the next period start.
// Backpressure: none; ena=0 freezes all counters/duty and forces PWM_OUT low combinationally.
//   ports: clk, rst_n (async, active-high despite the name), bus (slave: ena, buttons in, PWM_OUT out)
module pwm_duty_stepper
  import pwm_duty_stepper_pkg::*;
#(
  parameter int DEBOUNCE_DIV = DEFAULT_DEBOUNCE_DIV,
  parameter int PERIOD_STEPS = DEFAULT_PERIOD_STEPS,
  parameter int DUTY_RESET   = DEFAULT_DUTY_RESET
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_duty_stepper_if.slave  bus
);

  localparam int TW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam int DW = duty_width(PERIOD_STEPS);

  localparam logic [TW-1:0] TICK_LAST = TW'(DEBOUNCE_DIV - 1);
  localparam logic [DW-1:0] DUTY_MAX  = DW'(PERIOD_STEPS);
  localparam logic [DW-1:0] CNT_LAST  = DW'(PERIOD_STEPS - 1);
  localparam logic [DW-1:0] DUTY_INIT = DW'(DUTY_RESET);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] active_duty_q, active_duty_d;
  logic [DW-1:0] pwm_cnt_q, pwm_cnt_d, pwm_cnt_next;
  logic          pwm_out_q, pwm_out_d;
  logic          tick;
  logic          evt_inc, evt_dec;

  // Tick is gated by ena, so a disabled block generates no button events.
  assign tick = bus.ena && (tick_cnt_q == TICK_LAST);

  button_debouncer u_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.ui_increase_duty),
    .tick    (tick),
    .evt     (evt_inc)
  );

  button_debouncer u_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.ui_decrease_duty),
    .tick    (tick),
    .evt     (evt_dec)
  );

  always_comb begin
    tick_cnt_d    = tick_cnt_q;
    duty_d        = duty_q;
    pwm_cnt_next  = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;
    pwm_cnt_d     = pwm_cnt_q;
    active_duty_d = active_duty_q;
    pwm_out_d     = pwm_out_q;

    if (bus.ena) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

      // Simultaneous presses cancel; both ends saturate.
      if (evt_inc && !evt_dec && (duty_q != DUTY_MAX)) begin
        duty_d = duty_q + 1'b1;
      end else if (evt_dec && !evt_inc && (duty_q != '0)) begin
        duty_d = duty_q - 1'b1;
      end

      pwm_cnt_d = pwm_cnt_next;
      // Duty is only picked up at a period boundary so no period is truncated.
      if (pwm_cnt_next == '0) begin
        active_duty_d = duty_q;
      end
      pwm_out_d = (pwm_cnt_next < active_duty_d);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tick_cnt_q    <= '0;
      duty_q        <= DUTY_INIT;
      active_duty_q <= DUTY_INIT;
      pwm_cnt_q     <= '0;
      pwm_out_q     <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      duty_q        <= duty_d;
      active_duty_q <= active_duty_d;
      pwm_cnt_q     <= pwm_cnt_d;
      pwm_out_q     <= pwm_out_d;
    end
  end

  assign bus.PWM_OUT = bus.ena & pwm_out_q;

endmodule

// File: tb/tb_pwm_duty_stepper.sv
// Directed bench for pwm_duty_stepper with a behavioural model checked every clock.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_duty_stepper;

  localparam int DIV   = 4;
  localparam int STEPS = 10;
  localparam int DRST  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_duty_stepper_if bus ();

  pwm_duty_stepper #(
    .DEBOUNCE_DIV (DIV),
    .PERIOD_STEPS (STEPS),
    .DUTY_RESET   (DRST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: the block sees each raw level two clocks late; every DIV-th enabled
  // clock it takes a sample, and a press is a low sample followed by two highs.
  // PWM: period position advances once per enabled clock; the duty in force is
  // captured when the position returns to 0; output high while position < duty.
  int m_en_cycles = 0;
  int m_phase     = 0;
  int m_active    = DRST;
  int m_duty      = DRST;
  bit m_out       = 1'b0;
  bit inc_dly[2]  = '{1'b0, 1'b0};
  bit dec_dly[2]  = '{1'b0, 1'b0};
  int inc_samples[$];
  int dec_samples[$];

  always @(posedge clk or posedge rst_n) begin
    bit seen_inc, seen_dec, ev_inc, ev_dec;
    int n;
    if (rst_n) begin
      m_en_cycles = 0;
      m_phase     = 0;
      m_active    = DRST;
      m_duty      = DRST;
      m_out       = 1'b0;
      inc_dly     = '{1'b0, 1'b0};
      dec_dly     = '{1'b0, 1'b0};
      inc_samples = '{0, 0};
      dec_samples = '{0, 0};
    end else begin
      seen_inc   = inc_dly[1];
      seen_dec   = dec_dly[1];
      inc_dly[1] = inc_dly[0];
      inc_dly[0] = bus.ui_increase_duty;
      dec_dly[1] = dec_dly[0];
      dec_dly[0] = bus.ui_decrease_duty;
      ev_inc = 1'b0;
      ev_dec = 1'b0;
      if (bus.ena) begin
        if ((m_en_cycles % DIV) == DIV - 1) begin
          inc_samples.push_back(int'(seen_inc));
          dec_samples.push_back(int'(seen_dec));
          n = inc_samples.size();
          ev_inc = (inc_samples[n-1] == 1) && (inc_samples[n-2] == 1) && (inc_samples[n-3] == 0);
          ev_dec = (dec_samples[n-1] == 1) && (dec_samples[n-2] == 1) && (dec_samples[n-3] == 0);
          void'(inc_samples.pop_front());
          void'(dec_samples.pop_front());
        end
        m_en_cycles++;
        m_phase = (m_phase + 1) % STEPS;
        if (m_phase == 0) m_active = m_duty;
        m_out = (m_phase < m_active);
        if (ev_inc && !ev_dec)      m_duty = (m_duty < STEPS) ? m_duty + 1 : STEPS;
        else if (ev_dec && !ev_inc) m_duty = (m_duty > 0) ? m_duty - 1 : 0;
      end
    end
  end

  // Every-cycle comparison, half a clock away from the active edge.
  always @(negedge clk) begin
    check("pwm_out_vs_model", {31'b0, bus.PWM_OUT}, (bus.ena === 1'b1) ? {31'b0, m_out} : 32'd0);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit inc, input bit dec, input int hi, input int lo);
    bus.ui_increase_duty = inc;
    bus.ui_decrease_duty = dec;
    cyc(hi);
    bus.ui_increase_duty = 1'b0;
    bus.ui_decrease_duty = 1'b0;
    cyc(lo);
  endtask

  task automatic presses(input bit inc, input int count);
    repeat (count) press(inc, !inc, 10, 10);
  endtask

  // Counts high clocks over one full period after letting the new duty settle,
  // and pins the model's duty to the hand-computed value.
  task automatic measure(input string name, input int exp);
    int hc;
    hc = 0;
    cyc(25);
    repeat (STEPS) begin
      @(negedge clk);
      if (bus.PWM_OUT === 1'b1) hc++;
    end
    check({name, "_high_clocks"}, hc, exp);
    check({name, "_model_duty"}, m_duty, exp);
    #2;
  endtask

  initial begin
    rst_n                = 1'b1;
    bus.ena              = 1'b1;
    bus.ui_increase_duty = 1'b0;
    bus.ui_decrease_duty = 1'b0;
    #1;
    check("reset_pwm_low", {31'b0, bus.PWM_OUT}, 32'd0);
    cyc(3);
    rst_n = 1'b0;

    // Idle at default duty: 5 of 10 clocks high.
    cyc(20);
    measure("idle_default", 5);

    presses(1'b1, 3);
    measure("inc3", 8);

    presses(1'b0, 3);
    measure("dec3", 5);

    presses(1'b1, 7);
    measure("sat_high", 10);

    presses(1'b0, 12);
    measure("sat_low", 0);

    presses(1'b1, 5);
    measure("back_to_5", 5);

    press(1'b1, 1'b0, 2, 10);
    measure("glitch", 5);

    press(1'b1, 1'b1, 10, 10);
    measure("both", 5);

    press(1'b1, 1'b0, 100, 10);
    measure("hold_1us", 6);

    // Disabled for 300 ns with a press in the middle: output low, press ignored.
    bus.ena = 1'b0;
    cyc(5);
    check("ena0_pwm_low", {31'b0, bus.PWM_OUT}, 32'd0);
    press(1'b1, 1'b0, 10, 10);
    cyc(5);
    bus.ena = 1'b1;
    measure("ena_resume", 6);

    presses(1'b1, 2);
    measure("pre_reset", 8);

    // Reset mid-period: output drops at once, duty returns to default.
    cyc(3);
    rst_n = 1'b1;
    #1;
    check("midperiod_reset_pwm", {31'b0, bus.PWM_OUT}, 32'd0);
    cyc(2);
    rst_n = 1'b0;
    measure("after_reset", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
